// File: rtl/clock_monitor.sv
// clock_monitor
// Measures a slow clock (clk_in) from the clk_sys domain. It reports the
// rise-to-rise period and the rise-to-fall high time, checks the period
// against a window, and flags a stopped clock.
//
// Ports
//   clk_sys      in   system clock; all logic runs on its rising edge
//   rst_n        in   synchronous active-low reset
//   clk_in       in   monitored clock, asynchronous to clk_sys
//   rise_pulse   out  one-cycle strobe per detected clk_in rising edge
//   fall_pulse   out  one-cycle strobe per detected clk_in falling edge
//   period       out  last rise-to-rise interval in clk_sys cycles
//   high_time    out  last rise-to-fall interval in clk_sys cycles
//   period_valid out  one-cycle strobe when period/high_time update
//   in_range     out  last period within [PERIOD_MIN, PERIOD_MAX]
//   clk_lost     out  level, clk_in has stopped toggling
//   edge_count   out  rising edges seen since reset, wraps 255 -> 0
module clock_monitor #(
  parameter int PERIOD_MIN = 20,
  parameter int PERIOD_MAX = 28,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        clk_in,
  output logic        rise_pulse,
  output logic        fall_pulse,
  output logic [15:0] period,
  output logic [15:0] high_time,
  output logic        period_valid,
  output logic        in_range,
  output logic        clk_lost,
  output logic [7:0]  edge_count
);

  localparam logic [15:0] P_MIN     = 16'(PERIOD_MIN);
  localparam logic [15:0] P_MAX     = 16'(PERIOD_MAX);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [15:0] SAT       = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [2:0]  vld_q, vld_d;
  logic        armed_q, armed_d;
  logic        rise_q, rise_d, fall_q, fall_d;
  logic        rise_pulse_q, rise_pulse_d, fall_pulse_q, fall_pulse_d;
  logic [15:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [15:0] period_q, period_d, high_time_q, high_time_d;
  logic        period_valid_q, period_valid_d;
  logic        in_range_q, in_range_d;
  logic        clk_lost_q, clk_lost_d;
  logic [7:0]  edge_count_q, edge_count_d;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      vld_q          <= '0;
      armed_q        <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
      cnt_q          <= '0;
      hcnt_q         <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      clk_lost_q     <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      vld_q          <= vld_d;
      armed_q        <= armed_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      cnt_q          <= cnt_d;
      hcnt_q         <= hcnt_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      clk_lost_q     <= clk_lost_d;
      edge_count_q   <= edge_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    in_range_d     = in_range_q;
    clk_lost_d     = clk_lost_q;

    s1_d = clk_in;
    s2_d = s1_q;
    s3_d = s2_q;

    // vld_q marks which synchronizer stages hold real samples rather than
    // reset zeros. A rise only counts once s3 has actually been seen low, so
    // a clk_in already high at reset release cannot fake a rising edge.
    vld_d   = {vld_q[1:0], 1'b1};
    armed_d = armed_q | (vld_q[2] & ~s3_q);

    rise_d = s2_q & ~s3_q & armed_q;
    fall_d = ~s2_q & s3_q;

    rise_pulse_d = rise_q;
    fall_pulse_d = fall_q;
    edge_count_d = rise_q ? edge_count_q + 8'd1 : edge_count_q;

    // s3 is the level one stage behind s2, which lines the high-time count up
    // with rise_q: load 1 on the rise, count while high, freeze once low.
    if (rise_q)
      hcnt_d = 16'd1;
    else if (s3_q && hcnt_q != SAT)
      hcnt_d = hcnt_q + 16'd1;
    else
      hcnt_d = hcnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise_q) begin
          state_d = MEASURE;
          cnt_d   = 16'd1;
        end
      end
      MEASURE: begin
        // A rise on the timeout cycle wins over declaring the clock lost.
        if (rise_q) begin
          period_d       = cnt_q;
          high_time_d    = hcnt_q;
          in_range_d     = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
          period_valid_d = 1'b1;
          cnt_d          = 16'd1;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d    = LOST;
          clk_lost_d = 1'b1;
          in_range_d = 1'b0;
        end else if (cnt_q != SAT) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LOST: begin
        if (rise_q) begin
          state_d    = MEASURE;
          cnt_d      = 16'd1;
          clk_lost_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign clk_lost     = clk_lost_q;
  assign edge_count   = edge_count_q;

endmodule
